// File: rtl/time_sched_pkg.sv
// time_sched_pkg
//   Shared types and defaults for the alarm scheduler slice.
//   - sched_state_e : scanner FSM states
//   - alarm_slot_t  : one slot table entry {armed, deadline}
//   - deadline_due  : shared expiry predicate used by the scanner
// Deadlines are stored at TIME_W_MAX bits, so TIME_W must not exceed 64.
package time_sched_pkg;

  localparam int NUM_SLOTS_DEF = 4;
  localparam int TIME_W_DEF    = 64;
  localparam int TIME_W_MAX    = 64;

  typedef enum logic [0:0] {
    SCAN = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                  armed;
    logic [TIME_W_MAX-1:0] deadline;
  } alarm_slot_t;

  // A slot is due when it is armed, time is valid and its deadline has
  // been reached (unsigned compare; no wrap handling at 64 bits).
  function automatic logic deadline_due(
    input alarm_slot_t           entry,
    input logic [TIME_W_MAX-1:0] now,
    input logic                  now_ok
  );
    logic due;
    if (entry.armed && now_ok && (entry.deadline <= now)) begin
      due = 1'b1;
    end else begin
      due = 1'b0;
    end
    return due;
  endfunction

endpackage

// File: rtl/time_slot_table.sv
// time_slot_table
//   Register array of alarm slots.
//   Ports:
//     clk, rst_n               - clock, async active-low reset (all disarmed)
//     wr_en/wr_slot/wr_cancel/wr_time
//                              - request write port (arm or cancel)
//     clr_en/clr_slot          - scanner disarm port
//     rd_slot/rd_entry         - combinational read port (scanner pointer)
//     armed_mask               - armed bit of every slot
//   A request write and a scanner clear on the same slot resolve in favour
//   of the request, so a fresh arm is never lost to a stale match.
module time_slot_table
  import time_sched_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int TIME_W    = TIME_W_DEF,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic                 wr_cancel,
  input  logic [TIME_W-1:0]    wr_time,
  input  logic                 clr_en,
  input  logic [SLOT_W-1:0]    clr_slot,
  input  logic [SLOT_W-1:0]    rd_slot,
  output alarm_slot_t          rd_entry,
  output logic [NUM_SLOTS-1:0] armed_mask
);

  alarm_slot_t slot_r [NUM_SLOTS];

  // Slot storage: request write has priority over scanner clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        slot_r[k].armed    <= 1'b0;
        slot_r[k].deadline <= {TIME_W_MAX{1'b0}};
      end
    end else begin
      for (int k = 0; k < NUM_SLOTS; k++) begin
        if (wr_en && (wr_slot == SLOT_W'(k))) begin
          if (wr_cancel) begin
            slot_r[k].armed <= 1'b0;
          end else begin
            slot_r[k].armed    <= 1'b1;
            slot_r[k].deadline <= TIME_W_MAX'(wr_time);
          end
        end else if (clr_en && (clr_slot == SLOT_W'(k))) begin
          slot_r[k].armed <= 1'b0;
        end else begin
          slot_r[k] <= slot_r[k];
        end
      end
    end
  end

  // Read port at the scanner pointer.
  always_comb begin
    rd_entry = slot_r[rd_slot];
  end

  // Armed bits gathered into the status mask.
  always_comb begin
    armed_mask = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      armed_mask[k] = slot_r[k].armed;
    end
  end

endmodule

// File: rtl/time_alarm_scheduler.sv
// time_alarm_scheduler
//   Round-robin alarm scheduler sharing one deadline comparator among
//   NUM_SLOTS programmable slots.
//   Ports:
//     clk, rst_n                       - clock, async active-low reset
//     now_sec, now_valid               - current epoch seconds and its qualifier
//     req_valid/req_ready/req_slot/req_cancel/req_time
//                                      - arm/cancel request channel
//     fire_valid/fire_ready/fire_slot/fire_time
//                                      - expired-alarm output channel
//     armed_mask                       - armed bit per slot
//   SCAN visits one slot per cycle; a due slot is latched into the fire
//   register, disarmed, and held (HOLD) until the consumer accepts it.
module time_alarm_scheduler
  import time_sched_pkg::*;
#(
  parameter  int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter  int TIME_W    = TIME_W_DEF,
  localparam int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIME_W-1:0]    now_sec,
  input  logic                 now_valid,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SLOT_W-1:0]    req_slot,
  input  logic                 req_cancel,
  input  logic [TIME_W-1:0]    req_time,
  output logic                 fire_valid,
  input  logic                 fire_ready,
  output logic [SLOT_W-1:0]    fire_slot,
  output logic [TIME_W-1:0]    fire_time,
  output logic [NUM_SLOTS-1:0] armed_mask
);

  sched_state_e        state_r, state_s;
  logic [SLOT_W-1:0]   ptr_r, ptr_s;
  logic                fire_valid_r, fire_valid_s;
  logic [SLOT_W-1:0]   fire_slot_r, fire_slot_s;
  logic [TIME_W-1:0]   fire_time_r, fire_time_s;
  logic                req_ready_r;
  logic                req_acc_s;
  logic                req_hit_s;
  logic                due_s;
  logic                clr_en_s;
  alarm_slot_t         rd_entry_s;

  time_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .TIME_W    (TIME_W),
    .SLOT_W    (SLOT_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (req_acc_s),
    .wr_slot    (req_slot),
    .wr_cancel  (req_cancel),
    .wr_time    (req_time),
    .clr_en     (clr_en_s),
    .clr_slot   (ptr_r),
    .rd_slot    (ptr_r),
    .rd_entry   (rd_entry_s),
    .armed_mask (armed_mask)
  );

  // Request acceptance and collision with the slot under the scanner.
  // A request to the visited slot discards that visit's match so a
  // re-armed slot is judged against its new deadline next time round.
  always_comb begin
    req_acc_s = req_valid && req_ready_r;
    req_hit_s = req_acc_s && (req_slot == ptr_r);
    due_s     = deadline_due(rd_entry_s, TIME_W_MAX'(now_sec), now_valid);
  end

  // Scanner FSM next-state, pointer and fire register load.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    fire_valid_s = fire_valid_r;
    fire_slot_s  = fire_slot_r;
    fire_time_s  = fire_time_r;
    clr_en_s     = 1'b0;
    case (state_r)
      SCAN: begin
        if (due_s && !req_hit_s) begin
          // Pointer stays on the fired slot until the handshake.
          state_s      = HOLD;
          fire_valid_s = 1'b1;
          fire_slot_s  = ptr_r;
          fire_time_s  = rd_entry_s.deadline[TIME_W-1:0];
          clr_en_s     = 1'b1;
        end else begin
          ptr_s = ptr_r + SLOT_W'(1);
        end
      end
      HOLD: begin
        if (fire_ready) begin
          state_s      = SCAN;
          fire_valid_s = 1'b0;
          ptr_s        = ptr_r + SLOT_W'(1);
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s      = SCAN;
        fire_valid_s = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= SCAN;
      ptr_r        <= {SLOT_W{1'b0}};
      fire_valid_r <= 1'b0;
      fire_slot_r  <= {SLOT_W{1'b0}};
      fire_time_r  <= {TIME_W{1'b0}};
      req_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      fire_valid_r <= fire_valid_s;
      fire_slot_r  <= fire_slot_s;
      fire_time_r  <= fire_time_s;
      req_ready_r  <= 1'b1;
    end
  end

  assign req_ready  = req_ready_r;
  assign fire_valid = fire_valid_r;
  assign fire_slot  = fire_slot_r;
  assign fire_time  = fire_time_r;

endmodule

// File: tb/tb_time_alarm_scheduler.sv
// tb_time_alarm_scheduler
//   Directed bench for time_alarm_scheduler (NUM_SLOTS=4, TIME_W=64).
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_time_alarm_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] now_sec;
  logic        now_valid;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_slot;
  logic        req_cancel;
  logic [63:0] req_time;
  logic        fire_valid;
  logic        fire_ready;
  logic [1:0]  fire_slot;
  logic [63:0] fire_time;
  logic [3:0]  armed_mask;

  int n_cmp = 0;
  int n_err = 0;

  time_alarm_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .now_sec    (now_sec),
    .now_valid  (now_valid),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_slot   (req_slot),
    .req_cancel (req_cancel),
    .req_time   (req_time),
    .fire_valid (fire_valid),
    .fire_ready (fire_ready),
    .fire_slot  (fire_slot),
    .fire_time  (fire_time),
    .armed_mask (armed_mask)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [1:0] slot, input logic cancel, input logic [63:0] t);
    req_valid  = 1'b1;
    req_slot   = slot;
    req_cancel = cancel;
    req_time   = t;
    tick();
    req_valid  = 1'b0;
    req_cancel = 1'b0;
  endtask

  // Wait at most max_cyc cycles for fire_valid; a timeout shows up as a failed check.
  task automatic wait_fire(input int max_cyc, input string tag);
    int n;
    n = 0;
    while (!fire_valid && n < max_cyc) begin
      tick();
      n++;
    end
    check_eq({tag, "_fire_within"}, 64'(fire_valid), 64'd1);
  endtask

  task automatic ack_fire(input string tag);
    fire_ready = 1'b1;
    tick();
    fire_ready = 1'b0;
    check_eq({tag, "_drop_after_ack"}, 64'(fire_valid), 64'd0);
  endtask

  task automatic count_fires(input int cycles, output int fires);
    fires = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (fire_valid) fires++;
    end
  endtask

  // Next armed slot strictly after 'from' in round-robin order.
  function automatic int next_after(input int from, input logic [3:0] m);
    for (int d = 1; d <= 4; d++) begin
      if (m[(from + d) % 4]) return (from + d) % 4;
    end
    return -1;
  endfunction

  initial begin
    int          fires;
    int          first;
    int          unstable;
    int          nf;
    int          fslot [3];
    int          fcyc  [3];
    logic [63:0] ftime [3];
    logic [3:0]  m;
    int          exp_s;

    rst_n = 1'b0; now_sec = 64'd0; now_valid = 1'b0; req_valid = 1'b0;
    req_slot = 2'd0; req_cancel = 1'b0; req_time = 64'd0; fire_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin fslot[i] = 0; fcyc[i] = 0; ftime[i] = 64'd0; end

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'd0);
    check_eq("rst_fire_valid", 64'(fire_valid), 64'd0);
    check_eq("rst_fire_slot", 64'(fire_slot), 64'd0);
    check_eq("rst_fire_time", fire_time, 64'd0);
    check_eq("rst_armed_mask", 64'(armed_mask), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("req_ready_rise", 64'(req_ready), 64'd1);

    // Test 1: single alarm on a ramping clock
    now_sec = 64'd100; now_valid = 1'b1;
    drive_req(2'd2, 1'b0, 64'd105);
    check_eq("t1_armed", 64'(armed_mask), 64'b0100);
    fires = 0;
    for (int t = 101; t <= 104; t++) begin
      now_sec = 64'(t);
      tick();
      if (fire_valid) fires++;
    end
    check_eq("t1_no_early_fire", 64'(fires), 64'd0);
    now_sec = 64'd105;
    wait_fire(4, "t1");
    check_eq("t1_fire_slot", 64'(fire_slot), 64'd2);
    check_eq("t1_fire_time", fire_time, 64'd105);
    check_eq("t1_mask_cleared", 64'(armed_mask), 64'd0);
    ack_fire("t1");

    // Test 2: three expired slots under back-pressure, then drained
    fire_ready = 1'b0; now_sec = 64'd60;
    drive_req(2'd0, 1'b0, 64'd50);
    drive_req(2'd1, 1'b0, 64'd50);
    drive_req(2'd3, 1'b0, 64'd50);
    first = -1; unstable = 0;
    for (int i = 0; i < 10; i++) begin
      if (fire_valid) begin
        if (first < 0) first = int'(fire_slot);
        else if (int'(fire_slot) != first) unstable++;
      end else if (first >= 0) begin
        unstable++;
      end
      tick();
    end
    check_eq("t2_held_valid", 64'(fire_valid), 64'd1);
    check_eq("t2_held_stable", 64'(unstable), 64'd0);
    check_eq("t2_first_in_set", 64'(first == 0 || first == 1 || first == 3), 64'd1);
    if (first < 0) first = 0;
    check_eq("t2_held_time", fire_time, 64'd50);
    m = 4'b1011 & ~(4'b0001 << first);
    check_eq("t2_mask_during_hold", 64'(armed_mask), 64'(m));
    fire_ready = 1'b1;
    nf = 0;
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) tick();
      if (fire_valid) begin
        if (nf < 3) begin
          fslot[nf] = int'(fire_slot); ftime[nf] = fire_time; fcyc[nf] = c;
        end
        nf++;
      end
    end
    fire_ready = 1'b0;
    check_eq("t2_fire_count", 64'(nf), 64'd3);
    check_eq("t2_fire0_slot", 64'(fslot[0]), 64'(first));
    for (int k = 1; k < 3; k++) begin
      exp_s = next_after(fslot[k-1], m);
      check_eq($sformatf("t2_fire%0d_slot", k), 64'(fslot[k]), 64'(exp_s));
      check_eq($sformatf("t2_fire%0d_gap", k), 64'(fcyc[k] - fcyc[k-1]),
               64'(((exp_s - fslot[k-1] + 4) % 4) + 1));
      check_eq($sformatf("t2_fire%0d_time", k), ftime[k], 64'd50);
      if (exp_s >= 0) m[exp_s] = 1'b0;
    end
    check_eq("t2_mask_empty", 64'(armed_mask), 64'd0);

    // Test 3: cancel before expiry
    now_sec = 64'd150;
    drive_req(2'd1, 1'b0, 64'd200);
    check_eq("t3_armed", 64'(armed_mask), 64'b0010);
    repeat (3) tick();
    drive_req(2'd1, 1'b1, 64'd0);
    check_eq("t3_cancelled", 64'(armed_mask), 64'd0);
    now_sec = 64'd250;
    count_fires(10, fires);
    check_eq("t3_no_fire", 64'(fires), 64'd0);

    // Test 4: re-arm on the very cycle the scanner visits the slot.
    // Slot 1 fires first to pin the pointer: after its ack the scanner
    // visits slots 2, 3, then 0.
    drive_req(2'd0, 1'b0, 64'd300);
    drive_req(2'd1, 1'b0, 64'd0);
    wait_fire(8, "t4_sync");
    check_eq("t4_sync_slot", 64'(fire_slot), 64'd1);
    check_eq("t4_sync_time", fire_time, 64'd0);
    fire_ready = 1'b1;
    tick();
    fire_ready = 1'b0;
    now_sec = 64'd400;
    tick();
    tick();
    drive_req(2'd0, 1'b0, 64'd500);
    check_eq("t4_no_fire_collide", 64'(fire_valid), 64'd0);
    check_eq("t4_still_armed", 64'(armed_mask), 64'b0001);
    count_fires(10, fires);
    check_eq("t4_no_fire_before_500", 64'(fires), 64'd0);
    now_sec = 64'd500;
    wait_fire(4, "t4");
    check_eq("t4_fire_slot", 64'(fire_slot), 64'd0);
    check_eq("t4_fire_time", fire_time, 64'd500);
    ack_fire("t4");

    // Test 5: now_valid gates matching
    now_valid = 1'b0; now_sec = 64'd1000;
    drive_req(2'd3, 1'b0, 64'd0);
    count_fires(10, fires);
    check_eq("t5_no_fire_invalid", 64'(fires), 64'd0);
    check_eq("t5_armed", 64'(armed_mask), 64'b1000);
    now_valid = 1'b1;
    wait_fire(4, "t5");
    check_eq("t5_fire_slot", 64'(fire_slot), 64'd3);
    check_eq("t5_fire_time", fire_time, 64'd0);
    ack_fire("t5");

    // Test 6: reset asserted while a fire is held
    now_sec = 64'd2000;
    drive_req(2'd0, 1'b0, 64'd5000);
    drive_req(2'd2, 1'b0, 64'd0);
    wait_fire(8, "t6");
    check_eq("t6_fire_slot", 64'(fire_slot), 64'd2);
    check_eq("t6_pending_mask", 64'(armed_mask), 64'b0001);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_fire_valid", 64'(fire_valid), 64'd0);
    check_eq("t6_rst_mask", 64'(armed_mask), 64'd0);
    check_eq("t6_rst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    now_sec = 64'd6000;
    count_fires(10, fires);
    check_eq("t6_no_fire_after_rst", 64'(fires), 64'd0);
    check_eq("t6_mask_after_rst", 64'(armed_mask), 64'd0);
    check_eq("t6_req_ready_back", 64'(req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
